// File: rtl/push_down_stack_pkg.sv
// Shared defaults, pointer-width helper and op encoding for the push-down stack.
package push_down_stack_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 128;

    // Width needed to count 0..depth inclusive.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AW     = 7
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately left uninitialised on reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/push_down_stack.sv
// LIFO stack with empty/full flags. Define STACK_PEEK_EN to expose the current
// top of stack combinationally on data_o instead of the registered popped word.
module push_down_stack
    import push_down_stack_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PushPop,
    input  logic              En,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty,
    output logic              full
);

    localparam int unsigned SP_W = ptr_w(DEPTH);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] rdata;
    logic [AW-1:0]     raddr;
    op_e               op_c;
    logic              do_push_c, do_pop_c;

    assign op_c      = op_e'(PushPop);
    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SP_W'(DEPTH));
    assign do_push_c = En && (op_c == OP_PUSH) && !full;
    assign do_pop_c  = En && (op_c == OP_POP) && !empty;
    // Wraps when empty; that read is never consumed.
    assign raddr     = AW'(sp_q - SP_W'(1));

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (Clk),
        .we_i    (do_push_c),
        .waddr_i (sp_q[AW-1:0]),
        .wdata_i (data_i),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Stack pointer next state
    always_comb begin
        sp_d = sp_q;
        if (do_push_c) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop_c) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

`ifdef STACK_PEEK_EN
    assign data_o = empty ? '0 : rdata;
`else
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (do_pop_c) begin
            data_d = rdata;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
`endif

endmodule

// File: tb/tb_push_down_stack.sv
// Self-checking bench for push_down_stack (default build) against a queue-based LIFO model.
module tb_push_down_stack;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 128;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              PushPop;
    logic              En;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              empty;
    logic              full;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] model_data;

    push_down_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .PushPop (PushPop),
        .En      (En),
        .data_i  (data_i),
        .data_o  (data_o),
        .empty   (empty),
        .full    (full)
    );

    always #5 Clk = ~Clk;

    // Drive one operation, clock it, update the model, settle 1 time unit after the edge.
    task automatic step(input logic en, input logic pp, input logic [DATA_W-1:0] d);
        En      = en;
        PushPop = pp;
        data_i  = d;
        @(posedge Clk);
        if (!Rst && en) begin
            if (!pp && model_q.size() < DEPTH) model_q.push_back(d);
            else if (pp && model_q.size() > 0) model_data = model_q.pop_back();
        end
        #1;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_data = '0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'hAA);
            checks++;
            if (empty !== 1'b1 || full !== 1'b0 || data_o !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc%0d: empty=%b full=%b data_o=%h required 1 0 00", i, empty, full, data_o);
            end
        end
        Rst = 1'b0;
        #1;
    endtask

    task automatic test_pop_empty();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h5A);
            checks++;
            if (empty !== 1'b1 || full !== 1'b0 || data_o !== 8'h00) begin
                errors++;
                $display("FAIL pop_empty cyc%0d: empty=%b full=%b data_o=%h required 1 0 00", i, empty, full, data_o);
            end
        end
    endtask

    task automatic test_order();
        logic [DATA_W-1:0] vals [3];
        logic [DATA_W-1:0] exp  [3];
        vals = '{8'h11, 8'h22, 8'h33};
        exp  = '{8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, vals[i]);
        checks++;
        if (empty !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL order_push: empty=%b data_o=%h required 0 00", empty, data_o);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h00);
            checks++;
            if (data_o !== exp[i]) begin
                errors++;
                $display("FAIL order_pop%0d: data_o=%h required %h", i, data_o, exp[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL order_empty: empty=%b required 1", empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == DEPTH - 1) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_127: full=%b required 0", full);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b empty=%b required 1 0", full, empty);
        end
        step(1'b1, 1'b0, 8'hFF);
        checks++;
        if (full !== 1'b1 || data_o !== model_data) begin
            errors++;
            $display("FAIL push_full: full=%b data_o=%h required 1 %h", full, data_o, model_data);
        end
        step(1'b1, 1'b1, 8'h00);
        checks++;
        if (data_o !== 8'h80 || full !== 1'b0) begin
            errors++;
            $display("FAIL fill_pop1: data_o=%h full=%b required 80 0", data_o, full);
        end
        for (int i = DEPTH - 1; i >= 1; i--) begin
            step(1'b1, 1'b1, 8'h00);
            checks++;
            if (data_o !== 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d: data_o=%h required %h", i, data_o, 8'(i));
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: empty=%b required 1", empty);
        end
    endtask

    task automatic test_enable();
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i % 2), 8'($urandom));
            checks++;
            if (data_o !== 8'hC3 || empty !== 1'b0 || full !== 1'b0) begin
                errors++;
                $display("FAIL enable cyc%0d: data_o=%h empty=%b full=%b required c3 0 0", i, data_o, empty, full);
            end
        end
        // One entry (3C) must still be there
        step(1'b1, 1'b1, 8'h00);
        checks++;
        if (data_o !== 8'h3C || empty !== 1'b1) begin
            errors++;
            $display("FAIL enable_after: data_o=%h empty=%b required 3c 1", data_o, empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        En = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (empty !== 1'b1 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: empty=%b data_o=%h required 1 00", empty, data_o);
        end
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        step(1'b1, 1'b1, 8'h00);
        checks++;
        if (empty !== 1'b1 || data_o !== 8'h00 || full !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pop: empty=%b data_o=%h full=%b required 1 00 0", empty, data_o, full);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int unsigned push_pct;
            push_pct = (i < 300) ? 80 : 30;
            step(($urandom_range(99) < 85) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < push_pct) ? 1'b0 : 1'b1,
                 8'($urandom));
            checks++;
            if (data_o !== model_data ||
                empty !== (model_q.size() == 0) ||
                full !== (model_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL random cyc%0d: data_o=%h empty=%b full=%b required %h %b %b",
                         i, data_o, empty, full, model_data,
                         model_q.size() == 0, model_q.size() == DEPTH);
            end
        end
    endtask

    initial begin
        Rst     = 1'b1;
        En      = 1'b0;
        PushPop = 1'b0;
        data_i  = '0;
        model_reset();
        test_reset();
        test_pop_empty();
        test_order();
        test_fill();
        test_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
